// File: rtl/alu_ex_stage.sv
// Execute stage: operand forwarding, ALU and EX/MEM register; 1-cycle latency; stall holds, flush (wins over stall) loads a bubble.
// Optional ALU_OVF_EN adds ex_mem_ovf and a saturating ovf_count; overflow then suppresses reg_write.
module alu_ex_stage #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [2:0]            alu_control,
  input  logic [WIDTH-1:0]      rs_data,
  input  logic [WIDTH-1:0]      rt_data,
  input  logic [WIDTH-1:0]      imm,
  input  logic                  alu_src,
  input  logic [1:0]            fwd_a,
  input  logic [1:0]            fwd_b,
  input  logic [WIDTH-1:0]      ex_mem_fwd,
  input  logic [WIDTH-1:0]      mem_wb_fwd,
  input  logic [REG_ADDR_W-1:0] dest_in,
  input  logic                  reg_write_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  output logic                  ex_mem_valid,
  output logic [WIDTH-1:0]      ex_mem_result,
  output logic [WIDTH-1:0]      ex_mem_store,
  output logic [REG_ADDR_W-1:0] ex_mem_dest,
  output logic                  ex_mem_zero,
  output logic                  ex_mem_reg_write,
  output logic                  ex_mem_mem_read,
  output logic                  ex_mem_mem_write
`ifdef ALU_OVF_EN
  ,
  output logic                  ex_mem_ovf,
  output logic [7:0]            ovf_count
`endif
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;

  localparam logic [1:0] FWD_EX_MEM = 2'b01;
  localparam logic [1:0] FWD_MEM_WB = 2'b10;

  typedef struct packed {
    logic                  valid;
    logic [WIDTH-1:0]      result;
    logic [WIDTH-1:0]      store;
    logic [REG_ADDR_W-1:0] dest;
    logic                  zero;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
  } ex_mem_t;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] rt_fwd;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_result;
  logic             is_nop;
  logic             load_en;
  ex_mem_t          ex_mem_d;
  ex_mem_t          ex_mem_q;

  // Forwarding muxes; code 11 falls back to the register file like 00.
  always_comb begin
    op_a = rs_data;
    case (fwd_a)
      FWD_EX_MEM: op_a = ex_mem_fwd;
      FWD_MEM_WB: op_a = mem_wb_fwd;
      default:    op_a = rs_data;
    endcase
  end

  always_comb begin
    rt_fwd = rt_data;
    case (fwd_b)
      FWD_EX_MEM: rt_fwd = ex_mem_fwd;
      FWD_MEM_WB: rt_fwd = mem_wb_fwd;
      default:    rt_fwd = rt_data;
    endcase
  end

  assign op_b = alu_src ? imm : rt_fwd;
  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;

  always_comb begin
    alu_result = '0;
    case (alu_control)
      OP_ADD:  alu_result = sum;
      OP_SUB:  alu_result = diff;
      OP_AND:  alu_result = op_a & op_b;
      OP_OR:   alu_result = op_a | op_b;
      OP_NOT:  alu_result = ~op_a;
      default: alu_result = '0;
    endcase
  end

  assign is_nop = (alu_control > OP_NOT);

`ifdef ALU_OVF_EN
  logic ovf;

  // Signed overflow: operands agree in sign (after negating B for sub) but the result does not.
  always_comb begin
    ovf = 1'b0;
    case (alu_control)
      OP_ADD:  ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      OP_SUB:  ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
      default: ovf = 1'b0;
    endcase
  end
`endif

  always_comb begin
    ex_mem_d           = '0;
    ex_mem_d.valid     = 1'b1;
    ex_mem_d.result    = alu_result;
    ex_mem_d.store     = rt_fwd;
    ex_mem_d.dest      = dest_in;
    ex_mem_d.zero      = (alu_result == '0);
    ex_mem_d.reg_write = reg_write_in && !is_nop;
    ex_mem_d.mem_read  = mem_read_in && !is_nop;
    ex_mem_d.mem_write = mem_write_in && !is_nop;
`ifdef ALU_OVF_EN
    if (ovf) begin
      ex_mem_d.reg_write = 1'b0;
    end
`endif
  end

  // A real instruction is captured only when neither flushed nor stalled.
  assign load_en = !flush && !stall && in_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_mem_q <= '0;
    end else if (flush) begin
      ex_mem_q <= '0;
    end else if (!stall) begin
      if (in_valid) begin
        ex_mem_q <= ex_mem_d;
      end else begin
        ex_mem_q <= '0;
      end
    end
  end

`ifdef ALU_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (flush) begin
      ovf_q <= 1'b0;
    end else if (!stall) begin
      ovf_q <= in_valid && ovf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_count <= 8'd0;
    end else if (load_en && ovf && (ovf_count != 8'hFF)) begin
      ovf_count <= ovf_count + 8'd1;
    end
  end

  assign ex_mem_ovf = ovf_q;
`endif

  assign ex_mem_valid     = ex_mem_q.valid;
  assign ex_mem_result    = ex_mem_q.result;
  assign ex_mem_store     = ex_mem_q.store;
  assign ex_mem_dest      = ex_mem_q.dest;
  assign ex_mem_zero      = ex_mem_q.zero;
  assign ex_mem_reg_write = ex_mem_q.reg_write;
  assign ex_mem_mem_read  = ex_mem_q.mem_read;
  assign ex_mem_mem_write = ex_mem_q.mem_write;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Table-driven bench for alu_ex_stage with an expected-result queue; hand sequences for stall, reset and overflow.
module tb_alu_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, in_valid, alu_src;
  logic [2:0]  alu_control;
  logic [31:0] rs_data, rt_data, imm, ex_mem_fwd, mem_wb_fwd;
  logic [1:0]  fwd_a, fwd_b;
  logic [4:0]  dest_in;
  logic        reg_write_in, mem_read_in, mem_write_in;
  logic        ex_mem_valid, ex_mem_zero, ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write;
  logic [31:0] ex_mem_result, ex_mem_store;
  logic [4:0]  ex_mem_dest;
`ifdef ALU_OVF_EN
  logic        ex_mem_ovf;
  logic [7:0]  ovf_count;
`endif

  int total = 0;
  int bad   = 0;

  alu_ex_stage #(.WIDTH(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .alu_control(alu_control), .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
    .alu_src(alu_src), .fwd_a(fwd_a), .fwd_b(fwd_b), .ex_mem_fwd(ex_mem_fwd),
    .mem_wb_fwd(mem_wb_fwd), .dest_in(dest_in), .reg_write_in(reg_write_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .ex_mem_valid(ex_mem_valid), .ex_mem_result(ex_mem_result), .ex_mem_store(ex_mem_store),
    .ex_mem_dest(ex_mem_dest), .ex_mem_zero(ex_mem_zero), .ex_mem_reg_write(ex_mem_reg_write),
    .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_mem_write(ex_mem_mem_write)
`ifdef ALU_OVF_EN
    , .ex_mem_ovf(ex_mem_ovf), .ovf_count(ovf_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        inv, fl, st;
    logic [2:0]  ctl;
    logic [31:0] rs, rt, imm;
    logic        asrc;
    logic [1:0]  fa, fb;
    logic [31:0] exf, mwf;
    logic [4:0]  dest;
    logic        rw, mr, mw;
  } in_t;

  typedef struct {
    logic        valid;
    logic [31:0] result, store;
    logic [4:0]  dest;
    logic        zero, rw, mr, mw, ovf;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  exp_t q[$];
  vec_t vecs[13];

  function automatic in_t mk_in(input logic inv, input logic fl, input logic st, input logic [2:0] ctl,
                                input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] im,
                                input logic asrc, input logic [1:0] fa, input logic [1:0] fb,
                                input logic [31:0] exf, input logic [31:0] mwf, input logic [4:0] dest,
                                input logic rw, input logic mr, input logic mw);
    in_t r;
    r.inv = inv; r.fl = fl; r.st = st; r.ctl = ctl; r.rs = rs; r.rt = rt; r.imm = im;
    r.asrc = asrc; r.fa = fa; r.fb = fb; r.exf = exf; r.mwf = mwf; r.dest = dest;
    r.rw = rw; r.mr = mr; r.mw = mw;
    return r;
  endfunction

  function automatic exp_t mk_exp(input logic v, input logic [31:0] res, input logic [31:0] st,
                                  input logic [4:0] d, input logic z, input logic rw,
                                  input logic mr, input logic mw);
    exp_t r;
    r.valid = v; r.result = res; r.store = st; r.dest = d; r.zero = z;
    r.rw = rw; r.mr = mr; r.mw = mw; r.ovf = 1'b0;
    return r;
  endfunction

  task automatic drive(input in_t v);
    in_valid = v.inv; flush = v.fl; stall = v.st; alu_control = v.ctl;
    rs_data = v.rs; rt_data = v.rt; imm = v.imm; alu_src = v.asrc;
    fwd_a = v.fa; fwd_b = v.fb; ex_mem_fwd = v.exf; mem_wb_fwd = v.mwf;
    dest_in = v.dest; reg_write_in = v.rw; mem_read_in = v.mr; mem_write_in = v.mw;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s.queue: got=empty want=entry", tag);
      return;
    end
    e = q.pop_front();
    check({tag, ".valid"},  {31'd0, ex_mem_valid},     {31'd0, e.valid});
    check({tag, ".result"}, ex_mem_result,             e.result);
    check({tag, ".store"},  ex_mem_store,              e.store);
    check({tag, ".dest"},   {27'd0, ex_mem_dest},      {27'd0, e.dest});
    check({tag, ".zero"},   {31'd0, ex_mem_zero},      {31'd0, e.zero});
    check({tag, ".rw"},     {31'd0, ex_mem_reg_write}, {31'd0, e.rw});
    check({tag, ".mr"},     {31'd0, ex_mem_mem_read},  {31'd0, e.mr});
    check({tag, ".mw"},     {31'd0, ex_mem_mem_write}, {31'd0, e.mw});
`ifdef ALU_OVF_EN
    check({tag, ".ovf"},    {31'd0, ex_mem_ovf},       {31'd0, e.ovf});
`endif
  endtask

  // One clocked step: drive at negedge, queue the expectation, compare just after the edge.
  task automatic step(input in_t v, input exp_t e, input string tag);
    @(negedge clk);
    drive(v);
    q.push_back(e);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  exp_t zero_e;
  exp_t held;
  in_t  vi;
  exp_t ve;

  initial begin
    zero_e = mk_exp(0, 0, 0, 0, 0, 0, 0, 0);

    vecs[0]  = '{mk_in(1,0,0,3'b000,32'd5,32'd3,32'd7,1,2'b00,2'b00,0,0,5'd4,1,0,0),
                 mk_exp(1,32'd12,32'd3,5'd4,0,1,0,0)};
    vecs[1]  = '{mk_in(1,0,0,3'b001,32'd9,32'd9,32'd0,0,2'b01,2'b10,32'd20,32'd20,5'd5,1,0,0),
                 mk_exp(1,32'd0,32'd20,5'd5,1,1,0,0)};
    vecs[2]  = '{mk_in(1,0,0,3'b010,32'hF0F0,32'h0FF0,32'd0,0,2'b00,2'b00,0,0,5'd6,1,1,0),
                 mk_exp(1,32'h00F0,32'h0FF0,5'd6,0,1,1,0)};
    vecs[3]  = '{mk_in(1,0,0,3'b011,32'hF0,32'd0,32'h0F,1,2'b00,2'b00,0,0,5'd7,1,0,0),
                 mk_exp(1,32'hFF,32'd0,5'd7,0,1,0,0)};
    vecs[4]  = '{mk_in(1,0,0,3'b100,32'd0,32'h55,32'd0,0,2'b00,2'b00,0,0,5'd8,1,0,0),
                 mk_exp(1,32'hFFFFFFFF,32'h55,5'd8,0,1,0,0)};
    vecs[5]  = '{mk_in(1,0,0,3'b101,32'd3,32'h11,32'd4,1,2'b00,2'b00,0,0,5'd9,1,1,1),
                 mk_exp(1,32'd0,32'h11,5'd9,1,0,0,0)};
    vecs[6]  = '{mk_in(1,0,0,3'b110,32'd7,32'd2,32'd0,0,2'b00,2'b00,0,0,5'd10,1,0,1),
                 mk_exp(1,32'd0,32'd2,5'd10,1,0,0,0)};
    vecs[7]  = '{mk_in(1,0,0,3'b111,32'd1,32'd1,32'd0,0,2'b00,2'b00,0,0,5'd11,0,1,0),
                 mk_exp(1,32'd0,32'd1,5'd11,1,0,0,0)};
    vecs[8]  = '{mk_in(0,0,0,3'b000,32'd1,32'd1,32'd0,0,2'b00,2'b00,0,0,5'd12,1,0,1),
                 zero_e};
    vecs[9]  = '{mk_in(1,0,0,3'b000,32'd100,32'd1,32'd0,0,2'b11,2'b11,32'd999,32'd888,5'd13,1,0,0),
                 mk_exp(1,32'd101,32'd1,5'd13,0,1,0,0)};
    vecs[10] = '{mk_in(1,0,0,3'b001,32'd3,32'd0,32'd5,1,2'b00,2'b00,0,0,5'd14,1,0,1),
                 mk_exp(1,32'hFFFFFFFE,32'd0,5'd14,0,1,0,1)};
    vecs[11] = '{mk_in(1,0,0,3'b000,32'd0,32'd0,32'd1,1,2'b10,2'b01,32'h1234,32'hFFFFFFFF,5'd15,1,1,0),
                 mk_exp(1,32'd0,32'h1234,5'd15,1,1,1,0)};
    vecs[12] = '{mk_in(1,1,0,3'b000,32'd5,32'd0,32'd7,1,2'b00,2'b00,0,0,5'd16,1,0,0),
                 zero_e};

    rst = 1'b1;
    drive(mk_in(0,0,0,3'b000,0,0,0,0,2'b00,2'b00,0,0,5'd0,0,0,0));
    #12;
    q.push_back(zero_e);
    check_out("reset");
`ifdef ALU_OVF_EN
    check("reset.ovf_count", {24'd0, ovf_count}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].i, vecs[i].e, $sformatf("vec%0d", i));
    end

    // Stall holds through changed inputs; flush wins over stall.
    held = mk_exp(1, 32'd3, 32'd9, 5'd3, 0, 1, 0, 0);
    step(mk_in(1,0,0,3'b000,32'd1,32'd9,32'd2,1,2'b00,2'b00,0,0,5'd3,1,0,0), held, "stall.load");
    for (int k = 0; k < 3; k++) begin
      step(mk_in(1,0,1,3'b001,32'd50+k,32'd7,32'd1,0,2'b01,2'b10,32'd77,32'd66,5'd20,0,1,1),
           held, $sformatf("stall%0d", k));
    end
    step(mk_in(1,1,1,3'b000,32'd1,32'd1,32'd1,1,2'b00,2'b00,0,0,5'd21,1,0,0), zero_e, "stall_flush");

    // Asynchronous reset between edges.
    step(mk_in(1,0,0,3'b000,32'd5,32'd0,32'd7,1,2'b00,2'b00,0,0,5'd2,1,0,0),
         mk_exp(1,32'd12,32'd0,5'd2,0,1,0,0), "pre_rst");
    #3;
    rst = 1'b1;
    #1;
    q.push_back(zero_e);
    check_out("async_rst");
    step(mk_in(1,0,0,3'b000,32'd5,32'd0,32'd7,1,2'b00,2'b00,0,0,5'd2,1,0,0), zero_e, "rst_held");
    @(negedge clk);
    rst = 1'b0;
    step(mk_in(1,0,0,3'b011,32'hF0,32'd0,32'h0F,1,2'b00,2'b00,0,0,5'd1,1,0,0),
         mk_exp(1,32'hFF,32'd0,5'd1,0,1,0,0), "post_rst_or");

`ifdef ALU_OVF_EN
    check("ovf.count0", {24'd0, ovf_count}, 32'd0);
    ve = mk_exp(1, 32'h80000000, 32'd0, 5'd1, 0, 0, 0, 0);
    ve.ovf = 1'b1;
    step(mk_in(1,0,0,3'b000,32'h7FFFFFFF,32'd0,32'd1,1,2'b00,2'b00,0,0,5'd1,1,0,0), ve, "ovf.add");
    check("ovf.count1", {24'd0, ovf_count}, 32'd1);
    ve = mk_exp(1, 32'h7FFFFFFF, 32'd0, 5'd2, 0, 0, 0, 0);
    ve.ovf = 1'b1;
    step(mk_in(1,0,0,3'b001,32'h80000000,32'd0,32'd1,1,2'b00,2'b00,0,0,5'd2,1,0,0), ve, "ovf.sub");
    check("ovf.count2", {24'd0, ovf_count}, 32'd2);
    vi = mk_in(1,1,0,3'b000,32'h7FFFFFFF,32'd0,32'd1,1,2'b00,2'b00,0,0,5'd3,1,0,0);
    step(vi, zero_e, "ovf.flush");
    check("ovf.count_flush", {24'd0, ovf_count}, 32'd2);
    vi.fl = 1'b0;
    vi.st = 1'b1;
    step(vi, zero_e, "ovf.stall");
    check("ovf.count_stall", {24'd0, ovf_count}, 32'd2);
    vi.st = 1'b0;
    ve = mk_exp(1, 32'h80000000, 32'd0, 5'd3, 0, 0, 0, 0);
    ve.ovf = 1'b1;
    for (int k = 0; k < 253; k++) begin
      @(negedge clk);
      drive(vi);
      @(posedge clk);
    end
    #1;
    check("ovf.count255", {24'd0, ovf_count}, 32'd255);
    step(vi, ve, "ovf.sat");
    check("ovf.count_sat", {24'd0, ovf_count}, 32'd255);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
